// File: rtl/alu_seq.sv
// EX-stage execute unit: sixteen single-cycle ALU ops plus iterative unsigned
// multiply/divide behind a valid/ready handshake, with registered result and flags.
module alu_seq #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       alu_op,
   input  logic             flags_we,
   input  logic [WIDTH-1:0] s_1,
   input  logic [WIDTH-1:0] s_2,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_DIV  = 2'd2;

   localparam logic [4:0] OP_NAND = 5'h00;
   localparam logic [4:0] OP_ADD  = 5'h01;
   localparam logic [4:0] OP_ADDC = 5'h02;
   localparam logic [4:0] OP_OR   = 5'h03;
   localparam logic [4:0] OP_SUBC = 5'h04;
   localparam logic [4:0] OP_AND  = 5'h05;
   localparam logic [4:0] OP_SUB  = 5'h06;
   localparam logic [4:0] OP_XOR  = 5'h07;
   localparam logic [4:0] OP_NOT  = 5'h08;
   localparam logic [4:0] OP_SHL  = 5'h09;
   localparam logic [4:0] OP_SHR  = 5'h0A;
   localparam logic [4:0] OP_ROTL = 5'h0B;
   localparam logic [4:0] OP_ROTR = 5'h0C;
   localparam logic [4:0] OP_SSHR = 5'h0D;
   localparam logic [4:0] OP_SHRC = 5'h0E;
   localparam logic [4:0] OP_SHLC = 5'h0F;
   localparam logic [4:0] OP_MUL  = 5'h10;
   localparam logic [4:0] OP_MULH = 5'h11;
   localparam logic [4:0] OP_DIVU = 5'h12;
   localparam logic [4:0] OP_REMU = 5'h13;

   localparam int M  = WIDTH - 1;
   localparam int CW = $clog2(WIDTH);

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;
   logic               hi_sel;
   logic               we_q;

   logic               accept;
   logic               div_zero;
   logic               start_mul;
   logic               start_div;
   logic               c_in;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_o;
   logic               alu_upd;

   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     msum;
   logic [2*WIDTH-1:0] prod_n;
   logic [WIDTH-1:0]   mul_res;
   logic [3:0]         mul_flags;
   logic [WIDTH:0]     dshift;
   logic               dge;
   logic [WIDTH-1:0]   dsub;
   logic [WIDTH-1:0]   rem_n;
   logic [WIDTH-1:0]   quo_n;
   logic [WIDTH-1:0]   div_res;
   logic [3:0]         div_flags;

   assign in_ready  = (state == ST_IDLE);
   assign busy      = ~in_ready;
   assign accept    = in_valid & in_ready;
   assign div_zero  = (s_2 == '0);
   assign start_mul = (alu_op == OP_MUL) || (alu_op == OP_MULH);
   assign start_div = ((alu_op == OP_DIVU) || (alu_op == OP_REMU)) && !div_zero;

   always_comb begin
      c_in    = flags[0];
      sum     = {1'b0, s_1} + {1'b0, s_2} + {{WIDTH{1'b0}}, (alu_op == OP_ADDC) & c_in};
      diff    = {1'b0, s_1} - {1'b0, s_2} - {{WIDTH{1'b0}}, (alu_op == OP_SUBC) & ~c_in};
      alu_res = '0;
      alu_c   = 1'b0;
      alu_o   = 1'b0;
      alu_upd = 1'b1;
      case (alu_op)
         OP_NAND: alu_res = ~(s_1 & s_2);
         OP_ADD, OP_ADDC: begin
            alu_res = sum[M:0];
            alu_c   = sum[WIDTH];
            alu_o   = (s_1[M] == s_2[M]) && (sum[M] != s_1[M]);
         end
         OP_OR:   alu_res = s_1 | s_2;
         OP_SUB, OP_SUBC: begin
            alu_res = diff[M:0];
            alu_c   = diff[WIDTH];
            alu_o   = (s_1[M] != s_2[M]) && (diff[M] != s_1[M]);
         end
         OP_AND:  alu_res = s_1 & s_2;
         OP_XOR:  alu_res = s_1 ^ s_2;
         OP_NOT:  alu_res = ~s_2;
         OP_SHL: begin
            alu_res = {s_2[M-1:0], 1'b0};
            alu_c   = s_2[M];
         end
         OP_SHR: begin
            alu_res = {1'b0, s_2[M:1]};
            alu_c   = s_2[0];
         end
         OP_ROTL: begin
            alu_res = {s_2[M-1:0], s_2[M]};
            alu_c   = s_2[M];
         end
         OP_ROTR: begin
            alu_res = {s_2[0], s_2[M:1]};
            alu_c   = s_2[0];
         end
         OP_SSHR: begin
            alu_res = {s_2[M], s_2[M:1]};
            alu_c   = s_2[0];
         end
         OP_SHRC: begin
            alu_res = {c_in, s_2[M:1]};
            alu_c   = s_2[0];
         end
         OP_SHLC: begin
            alu_res = {s_2[M-1:0], c_in};
            alu_c   = s_2[M];
         end
         OP_MUL, OP_MULH: ;
         // Only reached on the single-cycle path when the divisor is zero.
         OP_DIVU: begin
            alu_res = '1;
            alu_o   = 1'b1;
         end
         OP_REMU: begin
            alu_res = s_1;
            alu_o   = 1'b1;
         end
         default: alu_upd = 1'b0;
      endcase
   end

   // Shift-add step: high half accumulates, multiplier bits shift out of the low half.
   always_comb begin
      addend    = prod[0] ? opnd : '0;
      msum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, addend};
      prod_n    = {msum, prod[M:1]};
      mul_res   = hi_sel ? prod_n[2*WIDTH-1:WIDTH] : prod_n[M:0];
      mul_flags = {1'b0, mul_res[M], mul_res == '0, prod_n[2*WIDTH-1:WIDTH] != '0};
   end

   // Restoring step: partial remainder stays below the divisor, so it fits WIDTH bits.
   always_comb begin
      dshift    = {rem, quo[M]};
      dge       = dshift >= {1'b0, opnd};
      dsub      = dshift[M:0] - opnd;
      rem_n     = dge ? dsub : dshift[M:0];
      quo_n     = {quo[M-1:0], dge};
      div_res   = hi_sel ? rem_n : quo_n;
      div_flags = {1'b0, div_res[M], div_res == '0, 1'b0};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         prod      <= '0;
         opnd      <= '0;
         rem       <= '0;
         quo       <= '0;
         hi_sel    <= 1'b0;
         we_q      <= 1'b0;
         result    <= '0;
         flags     <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  hi_sel <= alu_op[0];
                  we_q   <= flags_we;
                  opnd   <= s_2;
                  cnt    <= CW'(WIDTH - 1);
                  if (start_mul) begin
                     state <= ST_MUL;
                     prod  <= {{WIDTH{1'b0}}, s_1};
                  end else if (start_div) begin
                     state <= ST_DIV;
                     rem   <= '0;
                     quo   <= s_1;
                  end else begin
                     result    <= alu_res;
                     out_valid <= 1'b1;
                     if (flags_we && alu_upd)
                        flags <= {alu_o, alu_res[M], alu_res == '0, alu_c};
                  end
               end
            end
            ST_MUL: begin
               prod <= prod_n;
               cnt  <= cnt - CW'(1);
               if (cnt == '0) begin
                  state     <= ST_IDLE;
                  result    <= mul_res;
                  out_valid <= 1'b1;
                  if (we_q)
                     flags <= mul_flags;
               end
            end
            ST_DIV: begin
               rem <= rem_n;
               quo <= quo_n;
               cnt <= cnt - CW'(1);
               if (cnt == '0) begin
                  state     <= ST_IDLE;
                  result    <= div_res;
                  out_valid <= 1'b1;
                  if (we_q)
                     flags <= div_flags;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=16): directed vectors, randomized streams
// and reset/handshake scenarios against an arithmetic reference model.
module tb_alu_seq;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [4:0]    alu_op = '0;
   logic          flags_we = 1'b0;
   logic [W-1:0]  s_1 = '0;
   logic [W-1:0]  s_2 = '0;
   logic          out_valid;
   logic [W-1:0]  result;
   logic [3:0]    flags;
   logic          busy;

   int            checks = 0;
   int            errors = 0;
   logic [3:0]    fl_m = '0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .flags_we  (flags_we),
      .s_1       (s_1),
      .s_2       (s_2),
      .out_valid (out_valid),
      .result    (result),
      .flags     (flags),
      .busy      (busy)
   );

   // Reference model: plain integer arithmetic, tracks the architectural flags in fl_m.
   task automatic model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic we, output logic [15:0] r, output logic [3:0] f);
      int     cin, bin, s, sv;
      longint p;
      logic   c, o, upd;
      cin = int'(fl_m[0]);
      c = 1'b0; o = 1'b0; upd = 1'b1; r = '0;
      case (op)
         5'h00: r = ~(a & b);
         5'h01, 5'h02: begin
            bin = (op == 5'h02) ? cin : 0;
            s  = int'(a) + int'(b) + bin;
            sv = int'($signed(a)) + int'($signed(b)) + bin;
            r = s[15:0]; c = (s > 65535); o = (sv > 32767) || (sv < -32768);
         end
         5'h03: r = a | b;
         5'h04, 5'h06: begin
            bin = (op == 5'h04) ? 1 - cin : 0;
            s  = int'(a) - int'(b) - bin;
            sv = int'($signed(a)) - int'($signed(b)) - bin;
            r = s[15:0]; c = (s < 0); o = (sv > 32767) || (sv < -32768);
         end
         5'h05: r = a & b;
         5'h07: r = a ^ b;
         5'h08: r = ~b;
         5'h09: begin r = b << 1;                         c = b[15]; end
         5'h0A: begin r = b >> 1;                         c = b[0];  end
         5'h0B: begin r = (b << 1) | (b >> 15);           c = b[15]; end
         5'h0C: begin r = (b >> 1) | (b << 15);           c = b[0];  end
         5'h0D: begin r = (b >> 1) | (b & 16'h8000);      c = b[0];  end
         5'h0E: begin r = (b >> 1) | (fl_m[0] ? 16'h8000 : 16'h0000); c = b[0]; end
         5'h0F: begin r = (b << 1) | {15'd0, fl_m[0]};    c = b[15]; end
         5'h10, 5'h11: begin
            p = longint'(a) * longint'(b);
            r = (op == 5'h10) ? p[15:0] : p[31:16];
            c = (p >> 16) != 0;
         end
         5'h12, 5'h13: begin
            if (b == 0) begin
               r = (op == 5'h12) ? 16'hFFFF : a;
               o = 1'b1;
            end else begin
               r = (op == 5'h12) ? a / b : a % b;
            end
         end
         default: upd = 1'b0;
      endcase
      if (we && upd) fl_m = {o, r[15], r == 0, c};
      f = fl_m;
   endtask

   // Issue one op, then observe latency, result, flags, busy cycles and pulse end.
   task automatic do_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic we, output logic [15:0] r, output logic [3:0] f,
                        output int lat, output int low, output logic pulse_end);
      @(negedge clk);
      alu_op = op; s_1 = a; s_2 = b; flags_we = we; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      alu_op = 5'($urandom); s_1 = 16'($urandom); s_2 = 16'($urandom); flags_we = 1'($urandom);
      lat = -1; low = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
         if (!in_ready && busy) low++;
      end
      r = result; f = flags;
      @(negedge clk);
      pulse_end = out_valid;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", result); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
      rst_n = 1'b1;
      fl_m = '0;
   endtask

   typedef struct {
      logic [4:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic        we;
      logic [15:0] er;
      logic [3:0]  ef;
      int          elat;
   } vec_t;

   task automatic test_directed();
      vec_t v[10] = '{
         '{5'h01, 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 4'b1100, 1},
         '{5'h06, 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 4'b0101, 1},
         '{5'h01, 16'h0005, 16'h0005, 1'b0, 16'h000A, 4'b0101, 1},
         '{5'h02, 16'h0001, 16'h0001, 1'b1, 16'h0003, 4'b0000, 1},
         '{5'h10, 16'h0123, 16'h0010, 1'b1, 16'h1230, 4'b0000, 17},
         '{5'h11, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFE, 4'b0101, 17},
         '{5'h12, 16'd100,  16'd7,    1'b1, 16'd14,   4'b0000, 17},
         '{5'h13, 16'd100,  16'd7,    1'b1, 16'd2,    4'b0000, 17},
         '{5'h12, 16'd5,    16'd0,    1'b1, 16'hFFFF, 4'b1100, 1},
         '{5'h15, 16'h1234, 16'h5678, 1'b1, 16'h0000, 4'b1100, 1}
      };
      logic [15:0] r, mr;
      logic [3:0]  f, mf;
      int          lat, low;
      logic        pe;
      foreach (v[i]) begin
         do_op(v[i].op, v[i].a, v[i].b, v[i].we, r, f, lat, low, pe);
         model(v[i].op, v[i].a, v[i].b, v[i].we, mr, mf);
         checks++; if (r !== v[i].er) begin errors++; $display("FAIL dir%0d_result op=%h: got %h expected %h", i, v[i].op, r, v[i].er); end
         checks++; if (f !== v[i].ef) begin errors++; $display("FAIL dir%0d_flags op=%h: got %b expected %b", i, v[i].op, f, v[i].ef); end
         checks++; if (lat !== v[i].elat) begin errors++; $display("FAIL dir%0d_latency op=%h: got %0d expected %0d", i, v[i].op, lat, v[i].elat); end
         checks++; if (low !== ((v[i].elat == 17) ? 16 : 0)) begin errors++; $display("FAIL dir%0d_busy_cycles: got %0d expected %0d", i, low, (v[i].elat == 17) ? 16 : 0); end
         checks++; if (pe !== 1'b0) begin errors++; $display("FAIL dir%0d_pulse: out_valid still %b expected 0", i, pe); end
      end
   endtask

   // Single-cycle ops streamed with in_valid held high: one result per cycle.
   task automatic test_random_single();
      localparam int N = 60;
      logic [15:0] er, a, b;
      logic [3:0]  ef;
      logic [4:0]  op;
      logic        we;
      int          k;
      for (int i = 0; i <= N; i++) begin
         @(negedge clk);
         if (i > 0) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream%0d_valid: got %b expected 1", i - 1, out_valid); end
            checks++; if (result !== er) begin errors++; $display("FAIL stream%0d_result op=%h: got %h expected %h", i - 1, alu_op, result, er); end
            checks++; if (flags !== ef) begin errors++; $display("FAIL stream%0d_flags op=%h: got %b expected %b", i - 1, alu_op, flags, ef); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream%0d_ready: got %b expected 1", i - 1, in_ready); end
         end
         if (i < N) begin
            k  = $urandom_range(0, 19);
            a  = 16'($urandom);
            b  = 16'($urandom);
            we = ($urandom_range(0, 3) != 0);
            if (k < 16) op = 5'(k);
            else if (k < 18) op = 5'(5'h14 + $urandom_range(0, 11));
            else begin op = (k == 18) ? 5'h12 : 5'h13; b = '0; end
            alu_op = op; s_1 = a; s_2 = b; flags_we = we; in_valid = 1'b1;
            model(op, a, b, we, er, ef);
         end else begin
            in_valid = 1'b0;
         end
      end
   endtask

   task automatic test_random_muldiv();
      logic [15:0] r, er, a, b;
      logic [3:0]  f, ef;
      logic [4:0]  op;
      int          lat, low, elat;
      logic        pe;
      for (int i = 0; i < 14; i++) begin
         op = 5'(5'h10 + $urandom_range(0, 3));
         a  = 16'($urandom);
         b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         if (op >= 5'h12 && $urandom_range(0, 4) == 0) b = '0;
         elat = (op >= 5'h12 && b == 0) ? 1 : 17;
         do_op(op, a, b, 1'b1, r, f, lat, low, pe);
         model(op, a, b, 1'b1, er, ef);
         checks++; if (r !== er) begin errors++; $display("FAIL md%0d_result op=%h a=%h b=%h: got %h expected %h", i, op, a, b, r, er); end
         checks++; if (f !== ef) begin errors++; $display("FAIL md%0d_flags op=%h: got %b expected %b", i, op, f, ef); end
         checks++; if (lat !== elat) begin errors++; $display("FAIL md%0d_latency op=%h: got %0d expected %0d", i, op, lat, elat); end
      end
   endtask

   task automatic test_reset_mid_mul();
      logic [15:0] r, er;
      logic [3:0]  f, ef;
      int          lat, low;
      logic        pe, seen;
      do_op(5'h01, 16'h7FFF, 16'h0001, 1'b1, r, f, lat, low, pe);
      model(5'h01, 16'h7FFF, 16'h0001, 1'b1, er, ef);
      @(negedge clk);
      alu_op = 5'h10; s_1 = 16'hFFFF; s_2 = 16'hFFFF; flags_we = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmul_out_valid: got %b expected 0", out_valid); end
      checks++; if (result !== 16'h0000) begin errors++; $display("FAIL rstmul_result: got %h expected 0000", result); end
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL rstmul_flags: got %b expected 0000", flags); end
      @(negedge clk);
      rst_n = 1'b1;
      fl_m = '0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmul_no_valid: got %b expected 0", seen); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmul_in_ready: got %b expected 1", in_ready); end
      do_op(5'h01, 16'h0002, 16'h0003, 1'b1, r, f, lat, low, pe);
      model(5'h01, 16'h0002, 16'h0003, 1'b1, er, ef);
      checks++; if (r !== er || lat !== 1) begin errors++; $display("FAIL rstmul_after: got %h lat %0d expected %h lat 1", r, lat, er); end
   endtask

   // Add waits behind a mul with in_valid held; accepted in the mul's completion cycle.
   task automatic test_back_to_back();
      logic [15:0] a, b, c, d, em, ea;
      logic [3:0]  efm, efa;
      int          lat;
      a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
      @(negedge clk);
      alu_op = 5'h10; s_1 = a; s_2 = b; flags_we = 1'b1; in_valid = 1'b1;
      model(5'h10, a, b, 1'b1, em, efm);
      @(posedge clk);
      #1;
      alu_op = 5'h01; s_1 = c; s_2 = d;
      model(5'h01, c, d, 1'b1, ea, efa);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      checks++; if (lat !== 17) begin errors++; $display("FAIL b2b_mul_latency: got %0d expected 17", lat); end
      checks++; if (result !== em) begin errors++; $display("FAIL b2b_mul_result: got %h expected %h", result, em); end
      checks++; if (flags !== efm) begin errors++; $display("FAIL b2b_mul_flags: got %b expected %b", flags, efm); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_done: got %b expected 1", in_ready); end
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_add_valid: got %b expected 1", out_valid); end
      checks++; if (result !== ea) begin errors++; $display("FAIL b2b_add_result: got %h expected %h", result, ea); end
      checks++; if (flags !== efa) begin errors++; $display("FAIL b2b_add_flags: got %b expected %b", flags, efa); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random_single();
      test_random_muldiv();
      test_back_to_back();
      test_reset_mid_mul();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

endmodule
